// File: rtl/ternary_mvm_stream_if.sv
// ---------------------------------------------------------------------------
// ternary_mvm_stream_if
//   Bundles the command channel, result channel and status lines of the
//   ternary matrix-vector engine.
//
//   cmd_valid / cmd_data[15:0] / cmd_ready : command or data beat, valid/ready
//   out_valid / out_data / out_last / out_ready : signed row result, valid/ready
//   busy : engine not idle
//   err  : one-cycle pulse after an unrecognised header
//
//   Modports: slave = engine side, master = command/result consumer side.
// ---------------------------------------------------------------------------
interface ternary_mvm_stream_if #(
  parameter int ACC_WIDTH = 13
);
  logic                 cmd_valid;
  logic [15:0]          cmd_data;
  logic                 cmd_ready;
  logic                 out_valid;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready;
  logic                 busy;
  logic                 err;

  modport slave (
    input  cmd_valid, cmd_data, out_ready,
    output cmd_ready, out_valid, out_data, out_last, busy, err
  );

  modport master (
    output cmd_valid, cmd_data, out_ready,
    input  cmd_ready, out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/ternary_mvm_stream.sv
// ---------------------------------------------------------------------------
// ternary_mvm_stream
//   Ternary matrix-vector engine. Holds an OUT_LEN x IN_LEN matrix of
//   {-1, 0, +1} weights, accumulates a stream of signed activations against
//   it (all active rows in parallel, one activation per beat) and streams the
//   active row results back over a valid/ready channel.
//
//   Headers (decoded only when idle, cmd_data[15:12]):
//     0xA LOAD  : set active dims from [11:6] / [5:0] (+1, clamped), clear
//                 weights, then accept row-major weight beats (8 lanes/beat)
//     0xF MULT  : clear accumulators, then accept n_in activations, then drain
//     0xB READ  : drain the retained accumulators again
//     0x0 NOP   : nothing
//     other     : consumed, err pulses
//
//   Ports:
//     clk : clock, all state on the rising edge
//     rst : asynchronous, active-high reset
//     bus : ternary_mvm_stream_if.slave (command, result, busy, err)
// ---------------------------------------------------------------------------
module ternary_mvm_stream #(
  parameter int IN_LEN    = 16,
  parameter int OUT_LEN   = 8,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = IN_WIDTH + $clog2(IN_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  ternary_mvm_stream_if.slave   bus
);

  // Counters and dimensions all share one width: enough to hold 64.
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] IN_LEN_C  = CNT_W'(IN_LEN);
  localparam logic [CNT_W-1:0] OUT_LEN_C = CNT_W'(OUT_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACCUM,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_in_q,  n_in_d;
  logic [CNT_W-1:0] n_out_q, n_out_d;
  logic [CNT_W-1:0] row_q,   row_d;    // weight row in LOAD, result row in DRAIN
  logic [CNT_W-1:0] col_q,   col_d;    // 8-lane chunk within a row in LOAD
  logic [CNT_W-1:0] idx_q,   idx_d;    // activation index in ACCUM
  logic             err_q,   err_d;

  // Single-cycle strobes from the FSM into the datapath.
  logic clr_w;
  logic clr_acc;
  logic load_beat;
  logic acc_beat;

  logic                 cmd_ready;
  logic                 accept;
  logic [3:0]           nibble;
  logic [CNT_W-1:0]     hdr_n_in;
  logic [CNT_W-1:0]     hdr_n_out;
  logic [CNT_W-1:0]     n_chunks;
  logic [ACC_WIDTH-1:0] x_ext;

  logic signed [ACC_WIDTH-1:0] acc_all [OUT_LEN];
  logic signed [ACC_WIDTH-1:0] acc_rd;

  assign cmd_ready = (state_q != S_DRAIN);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign nibble    = bus.cmd_data[15:12];

  assign hdr_n_in  = {1'b0, bus.cmd_data[11:6]} + CNT_W'(1);
  assign hdr_n_out = {1'b0, bus.cmd_data[5:0]}  + CNT_W'(1);

  // Beats per weight row: ceil(n_in / 8).
  assign n_chunks  = (n_in_q + CNT_W'(7)) >> 3;

  assign x_ext = {{(ACC_WIDTH-IN_WIDTH){bus.cmd_data[IN_WIDTH-1]}},
                  bus.cmd_data[IN_WIDTH-1:0]};

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_in_q  <= IN_LEN_C;
      n_out_q <= OUT_LEN_C;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_in_q  <= n_in_d;
      n_out_q <= n_out_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and datapath strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    n_in_d    = n_in_q;
    n_out_d   = n_out_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    clr_w     = 1'b0;
    clr_acc   = 1'b0;
    load_beat = 1'b0;
    acc_beat  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (nibble)
            4'hA: begin
              n_in_d  = (hdr_n_in  > IN_LEN_C)  ? IN_LEN_C  : hdr_n_in;
              n_out_d = (hdr_n_out > OUT_LEN_C) ? OUT_LEN_C : hdr_n_out;
              row_d   = '0;
              col_d   = '0;
              clr_w   = 1'b1;
              state_d = S_LOAD;
            end
            4'hF: begin
              idx_d   = '0;
              clr_acc = 1'b1;
              state_d = S_ACCUM;
            end
            4'hB: begin
              row_d   = '0;
              state_d = S_DRAIN;
            end
            4'h0: ;
            default: err_d = 1'b1;
          endcase
        end
      end

      S_LOAD: begin
        if (accept) begin
          load_beat = 1'b1;
          if (col_q == n_chunks - CNT_W'(1)) begin
            col_d = '0;
            if (row_q == n_out_q - CNT_W'(1)) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + CNT_W'(1);
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end

      S_ACCUM: begin
        if (accept) begin
          acc_beat = 1'b1;
          if (idx_q == n_in_q - CNT_W'(1)) begin
            idx_d   = '0;
            row_d   = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == n_out_q - CNT_W'(1)) begin
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-row weight storage and accumulator
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < OUT_LEN; gi++) begin : g_row
    logic [1:0]                  w_q [IN_LEN];
    logic [1:0]                  w_sel;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        row_load;
    logic                        row_active;

    assign row_load   = load_beat && (row_q == CNT_W'(gi));
    assign row_active = (CNT_W'(gi) < n_out_q);

    // Every weight is cleared by the LOAD header, so columns beyond n_in
    // (whose lanes are ignored) read back as 0.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < IN_LEN; i++) w_q[i] <= 2'b00;
      end else if (clr_w) begin
        for (int i = 0; i < IN_LEN; i++) w_q[i] <= 2'b00;
      end else if (row_load) begin
        for (int i = 0; i < IN_LEN; i++) begin
          if ((col_q == CNT_W'(i / 8)) && (CNT_W'(i) < n_in_q))
            w_q[i] <= bus.cmd_data[2*(i%8) +: 2];
        end
      end
    end

    // Weight for the activation currently on the bus.
    always_comb begin
      w_sel = 2'b00;
      for (int i = 0; i < IN_LEN; i++) begin
        if (idx_q == CNT_W'(i)) w_sel = w_q[i];
      end
    end

    // 01 adds, 11 subtracts, 00 and the spare code 10 both hold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
      end else if (clr_acc) begin
        acc_q <= '0;
      end else if (acc_beat && row_active) begin
        case (w_sel)
          2'b01:   acc_q <= acc_q + $signed(x_ext);
          2'b11:   acc_q <= acc_q - $signed(x_ext);
          default: acc_q <= acc_q;
        endcase
      end
    end

    assign acc_all[gi] = acc_q;
  end

  // Result row select for the drain.
  always_comb begin
    acc_rd = '0;
    for (int j = 0; j < OUT_LEN; j++) begin
      if (row_q == CNT_W'(j)) acc_rd = acc_all[j];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: the drain is driven straight from state, so the result row and
  // its last flag hold naturally while the consumer stalls.
  // -------------------------------------------------------------------------
  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_last  = (state_q == S_DRAIN) && (row_q == n_out_q - CNT_W'(1));
  assign bus.out_data  = (state_q == S_DRAIN) ? acc_rd : '0;
  assign bus.err       = err_q;

endmodule

// File: doc/ternary_mvm_stream.md
# ternary_mvm_stream

Parametrised ternary matrix-vector engine: the next-generation core behind the tiny-ternary top level. It accepts 16-bit command/data beats over a valid/ready channel and stores an OUT_LEN x IN_LEN ternary weight matrix. It accumulates signed activations against that matrix and streams the OUT_LEN signed results back over a second valid/ready channel. Unlike the first generation, the core has:
- run-time active dimensions;
- a finite multiply pass that returns to idle;
- output backpressure;
- a re-read command.

## Interface
- IN_LEN, 16: maximum input-vector length; 1..64.
- OUT_LEN, 8: maximum output-vector length; 1..64.
- IN_WIDTH, 8: activation width, signed; 2..16.
- ACC_WIDTH, IN_WIDTH+$clog2(IN_LEN)+1: accumulator/result width, signed.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command/data beat valid.
- cmd_data  in  16  command header or data beat.
- cmd_ready  out  1  beat accepted when cmd_valid && cmd_ready.
- out_valid  out  1  result valid.
- out_data  out  ACC_WIDTH  signed result for current row.
- out_last  out  1  high with the final row's result.
- out_ready  in  1  result accepted when out_valid && out_ready.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on an unrecognised header.

## Operation
- States: IDLE, LOAD, ACCUM, DRAIN.
- cmd_ready = 1 in IDLE, LOAD and ACCUM; 0 in DRAIN.
- Headers are decoded in IDLE only, from cmd_data[15:12]:
  - 0xA LOAD: n_in = cmd_data[11:6]+1, n_out = cmd_data[5:0]+1, each clamped to IN_LEN / OUT_LEN. Clears every weight to 0. Next state LOAD.
  - 0xF MULT: clears all accumulators. Next state ACCUM.
  - 0xB READ: next state DRAIN; re-emits the retained results without recomputing.
  - 0x0: NOP, stay in IDLE.
  - Any other value: consumed, err pulses, stay in IDLE.
- Ternary encoding, 2 bits per weight: 01 = +1, 11 = -1, 00 = 0, 10 = 0. Code 10 raises no error.
- LOAD:
  - Each beat carries 8 weights; lane k is cmd_data[2k+1:2k].
  - Beat order is row-major: for j in 0..n_out-1, for c in 0..ceil(n_in/8)-1, lane k writes w[j][8c+k].
  - Lanes with index >= n_in are ignored.
  - After n_out*ceil(n_in/8) accepted beats, go to IDLE.
- ACCUM:
  - Beat i (0..n_in-1) carries activation x_i = sign-extended cmd_data[IN_WIDTH-1:0].
  - On each accepted beat, every row j < n_out updates in parallel: acc[j] += w[j][i]*x_i (add, subtract or hold).
  - Arithmetic is two's complement, ACC_WIDTH bits, wrapping on overflow.
  - After beat n_in-1, go to DRAIN.
- DRAIN:
  - Emits acc[0]..acc[n_out-1] in order; out_last accompanies row n_out-1.
  - After the last accepted result, go to IDLE.
- Accumulators are retained until the next MULT header or reset, so READ repeats them.
- Configuration defaults (n_in = IN_LEN, n_out = OUT_LEN) hold until the first LOAD.

## Timing
- Reset (async assert, sync release), all of the following take effect immediately:
  - state IDLE;
  - all weights and accumulators 0;
  - n_in = IN_LEN, n_out = OUT_LEN;
  - out_valid 0, out_data 0, out_last 0, busy 0, err 0;
  - cmd_ready 1 once rst deasserts.
- Header accept in cycle t: the new state and busy = 1 are visible at t+1.
- Accumulator update: registered on the accepting edge.
- Result latency: out_valid rises 1 cycle after the last activation is accepted, or 1 cycle after a READ header.
- Throughput: one beat per cycle on both channels when there is no backpressure.
- Output hold: while out_valid && !out_ready, out_data and out_last hold stable. out_valid never drops without a transfer.
- Return to idle: the cycle after the out_last transfer, state is IDLE, busy is 0 and cmd_ready is 1.
- err: asserted exactly one cycle, the cycle after the bad header is accepted.
- Beats in LOAD/ACCUM are always data; header nibbles are not decoded there.
- Reset mid-LOAD, mid-ACCUM or mid-DRAIN: the whole pass is aborted and all state returns to reset values. No partial result is emitted.

## Test plan
- Reset defaults: MULT 0xF000, then 16 activations of 0x05 → 8 results, all 0; out_last on the 8th; busy 0 the following cycle.
- Load and multiply:
  - LOAD 0xA0C1 (n_in = 4, n_out = 2), then weight beats 0x004D (+1, -1, 0, +1) and 0x00FF (all -1).
  - MULT 0xF000, then activations 10, 20, -3 (0xFD), 7.
  - Expected: -3, then -34 with out_last.
- Backpressure and re-read:
  - Hold out_ready low 3 cycles during DRAIN → out_data stays -3 and out_valid stays 1.
  - Then READ 0xB000 → -3, -34 re-emitted identically.
- Clamp and reserved code:
  - LOAD 0xAFFF with defaults → n_in = 16, n_out = 8, so 16 weight beats expected.
  - A lane coded 10 acts as weight 0.
- Bad header and reset:
  - 0x3123 in IDLE → err high for exactly 1 cycle, state stays IDLE.
  - Assert rst after 2 of 4 activations → no out_valid; a following MULT pass returns all zeros.
